// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave engine.
package spi_pkg;

  typedef enum logic {IDLE, ACTIVE} spi_state_e;

  // {CPOL, CPHA} encodings of the four standard SPI modes
  localparam logic [1:0] SPI_MODE_0 = 2'b00;
  localparam logic [1:0] SPI_MODE_1 = 2'b01;
  localparam logic [1:0] SPI_MODE_2 = 2'b10;
  localparam logic [1:0] SPI_MODE_3 = 2'b11;

  function automatic int bit_cnt_width(input int data_width);
    return (data_width > 1) ? $clog2(data_width) : 1;
  endfunction

endpackage

// File: rtl/spi_sclk_edge.sv
// Oversampled SCLK edge detector: turns the synchronised SCLK into
// single-cycle sample/shift strobes according to CPOL/CPHA.
module spi_sclk_edge #(
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0
) (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic sclk_i,
  input  logic cs_n_i,
  output logic sample_stb,
  output logic shift_stb
);

  logic sclk_q;
  logic sclk_edge;
  logic leading;

  always_ff @(posedge clk_i) begin
    if (!arstn_i) sclk_q <= CPOL;
    else          sclk_q <= sclk_i;
  end

  // a leading edge is one that leaves the idle level
  assign sclk_edge  = (sclk_i != sclk_q) && !cs_n_i;
  assign leading    = (sclk_i != CPOL);
  assign sample_stb = sclk_edge && (leading ^ CPHA);
  assign shift_stb  = sclk_edge && !(leading ^ CPHA);

endmodule

// File: rtl/spi_slave_core.sv
// Full-duplex SPI slave engine bridging SPI to AXI-Stream in the system clock domain.
// Optional sticky RX overrun flag enabled by defining SPI_SLAVE_OVERRUN_EN.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  sclk_i,
  input  logic                  cs_n_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  output logic                  miso_oe_o,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
  input  logic                  s_axis_tvalid_i,
  output logic                  s_axis_tready_o,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
  output logic                  m_axis_tvalid_o,
  input  logic                  m_axis_tready_i,
  output logic                  overrun_o
);

  localparam int CNT_W = bit_cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  spi_state_e            state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] tx_advanced;
  logic [DATA_WIDTH-1:0] load_word;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  oe_q;
  logic                  sample_stb;
  logic                  shift_stb;
  logic                  active;
  logic                  cs_start;
  logic                  last_bit;
  logic                  tx_load;
  logic                  s_hs;
  logic                  m_hs;
  logic                  rx_done;
  logic                  rx_accept;

  spi_sclk_edge #(
    .CPOL(CPOL),
    .CPHA(CPHA)
  ) u_edge (
    .clk_i     (clk_i),
    .arstn_i   (arstn_i),
    .sclk_i    (sclk_i),
    .cs_n_i    (cs_n_i),
    .sample_stb(sample_stb),
    .shift_stb (shift_stb)
  );

  assign active    = (state == ACTIVE) && !cs_n_i;
  assign cs_start  = (state == IDLE) && !cs_n_i;
  assign last_bit  = (bit_cnt == LAST_BIT);
  assign s_hs      = s_axis_tvalid_i && !hold_valid;
  assign m_hs      = m_valid && m_axis_tready_i;
  assign rx_done   = active && sample_stb && last_bit;
  assign rx_accept = rx_done && (!m_valid || m_axis_tready_i);

  // word boundary: CPHA=0 preloads at CS assertion, both modes reload on a shift edge at bit 0
  assign tx_load   = (active && shift_stb && (bit_cnt == '0)) || (cs_start && (CPHA == 1'b0));
  assign load_word = hold_valid ? hold_data : '0;

  assign rx_next     = MSB_FIRST ? {rx_shift[DATA_WIDTH-2:0], mosi_i}
                                 : {mosi_i, rx_shift[DATA_WIDTH-1:1]};
  assign tx_advanced = MSB_FIRST ? {tx_shift[DATA_WIDTH-2:0], 1'b0}
                                 : {1'b0, tx_shift[DATA_WIDTH-1:1]};

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
    end else begin
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (!cs_n_i) state <= ACTIVE;
          if (tx_load) tx_shift <= load_word;
        end
        default: begin
          if (cs_n_i) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            tx_shift <= '0;
          end else begin
            if (sample_stb) begin
              rx_shift <= rx_next;
              bit_cnt  <= last_bit ? '0 : bit_cnt + CNT_W'(1);
            end
            if (shift_stb) tx_shift <= tx_load ? load_word : tx_advanced;
          end
        end
      endcase
    end
  end

  // a fresh handshake always finds the register empty, so a coincident load already saw zeros
  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (s_hs) begin
      hold_valid <= 1'b1;
      hold_data  <= s_axis_tdata_i;
    end else if (tx_load) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      oe_q <= !cs_n_i;
      if (rx_accept) begin
        m_data  <= rx_next;
        m_valid <= 1'b1;
      end else if (m_hs) begin
        m_valid <= 1'b0;
      end
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clk_i) begin
    if (!arstn_i)                    overrun_q <= 1'b0;
    else if (rx_done && !rx_accept)  overrun_q <= 1'b1;
  end

  assign overrun_o = overrun_q;
`else
  assign overrun_o = 1'b0;
`endif

  assign miso_o          = MSB_FIRST ? tx_shift[DATA_WIDTH-1] : tx_shift[0];
  assign miso_oe_o       = oe_q;
  assign s_axis_tready_o = !hold_valid;
  assign m_axis_tdata_o  = m_data;
  assign m_axis_tvalid_o = m_valid;

endmodule

// File: tb/tb_spi_slave_core.sv
// Scoreboard bench driving a mode-0 and a mode-3 slave from one SPI master model.
module tb_spi_slave_core;

  localparam int W    = 8;
  localparam int HALF = 5;
`ifdef SPI_SLAVE_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic arstn = 1'b0;
  logic csN   = 1'b1;
  logic mosi  = 1'b0;
  logic sclkA = 1'b0;
  logic sclkB = 1'b1;
  logic mReady = 1'b1;
  logic [W-1:0] sDataA = '0, sDataB = '0;
  logic sValidA = 1'b0, sValidB = 1'b0;
  logic misoA, misoOeA, sReadyA, mValidA, overrunA;
  logic misoB, misoOeB, sReadyB, mValidB, overrunB;
  logic [W-1:0] mDataA, mDataB;

  int testsRun = 0;
  int testsFailed = 0;
  logic [W-1:0] expA[$];
  logic [W-1:0] expB[$];
  bit modelHeld = 1'b0;
  bit expOverrun = 1'b0;
  logic [W-1:0] mosiWord[8];
  logic [W-1:0] txWord[8];
  bit txHas[8];

  always #5 clk = ~clk;

  spi_slave_core #(.DATA_WIDTH(W), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) dutA (
    .clk_i(clk), .arstn_i(arstn), .sclk_i(sclkA), .cs_n_i(csN), .mosi_i(mosi),
    .miso_o(misoA), .miso_oe_o(misoOeA),
    .s_axis_tdata_i(sDataA), .s_axis_tvalid_i(sValidA), .s_axis_tready_o(sReadyA),
    .m_axis_tdata_o(mDataA), .m_axis_tvalid_o(mValidA), .m_axis_tready_i(mReady),
    .overrun_o(overrunA));

  spi_slave_core #(.DATA_WIDTH(W), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1)) dutB (
    .clk_i(clk), .arstn_i(arstn), .sclk_i(sclkB), .cs_n_i(csN), .mosi_i(mosi),
    .miso_o(misoB), .miso_oe_o(misoOeB),
    .s_axis_tdata_i(sDataB), .s_axis_tvalid_i(sValidB), .s_axis_tready_o(sReadyB),
    .m_axis_tdata_o(mDataB), .m_axis_tvalid_o(mValidB), .m_axis_tready_i(mReady),
    .overrun_o(overrunB));

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Monitor: every RX beat handed over is matched against the scoreboard
  always @(negedge clk) begin
    if (arstn && mValidA && mReady) begin
      if (expA.size() == 0) begin
        testsRun++; testsFailed++;
        $display("[TB] FAIL rx beat A: got unexpected 0x%0h, expected no beat", mDataA);
      end else checkOutput("rx beat A", mDataA, expA.pop_front());
    end
    if (arstn && mValidB && mReady) begin
      if (expB.size() == 0) begin
        testsRun++; testsFailed++;
        $display("[TB] FAIL rx beat B: got unexpected 0x%0h, expected no beat", mDataB);
      end else checkOutput("rx beat B", mDataB, expB.pop_front());
    end
  end

  // Reference model of the RX output register: one slot, drop when full and not ready
  task automatic modelRx(input logic [W-1:0] w);
    if (!modelHeld || mReady) begin
      expA.push_back(w);
      expB.push_back(w);
      if (!mReady) modelHeld = 1'b1;
    end else begin
      expOverrun = OVR_EN;
    end
  endtask

  task automatic pushTx(input logic [W-1:0] w);
    bit hsA, hsB;
    sDataA = w; sDataB = w;
    sValidA = 1'b1; sValidB = 1'b1;
    for (int c = 0; c < 20 && (sValidA || sValidB); c++) begin
      hsA = sReadyA;
      hsB = sReadyB;
      waitClk(1);
      if (hsA) sValidA = 1'b0;
      if (hsB) sValidB = 1'b0;
    end
    if (sValidA || sValidB) begin
      testsRun++; testsFailed++;
      $display("[TB] FAIL tx handshake: got ready A=%0b B=%0b, expected handshake within 20 cycles", sReadyA, sReadyB);
      sValidA = 1'b0; sValidB = 1'b0;
    end
  endtask

  // One CS frame of n words; cutBits>=0 aborts the first word after that many bits
  task automatic applyStimulus(input int n, input int cutBits);
    logic [W-1:0] cur;
    int nBits;
    if (txHas[0]) pushTx(txWord[0]);
    csN = 1'b0;
    waitClk(4);
    checkOutput("miso_oe A", misoOeA, 1);
    checkOutput("miso_oe B", misoOeB, 1);
    for (int k = 0; k < n; k++) begin
      cur = txHas[k] ? txWord[k] : '0;
      nBits = (cutBits >= 0) ? cutBits : W;
      for (int i = 0; i < nBits; i++) begin
        mosi = mosiWord[k][W-1-i];
        sclkB = 1'b0;
        waitClk(HALF);
        if (i == 3 && k + 1 < n && txHas[k+1]) pushTx(txWord[k+1]);
        checkOutput($sformatf("miso A w%0d b%0d", k, i), misoA, cur[W-1-i]);
        checkOutput($sformatf("miso B w%0d b%0d", k, i), misoB, cur[W-1-i]);
        if (i == W - 1) modelRx(mosiWord[k]);
        sclkA = 1'b1; sclkB = 1'b1;
        waitClk(HALF);
        sclkA = 1'b0;
        waitClk(HALF);
      end
    end
    csN = 1'b1;
    waitClk(4);
    checkOutput("overrun A", overrunA, expOverrun);
    checkOutput("overrun B", overrunB, expOverrun);
  endtask

  task automatic clearTx();
    for (int k = 0; k < 8; k++) txHas[k] = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " miso A"}, misoA, 0);
    checkOutput({tag, " miso B"}, misoB, 0);
    checkOutput({tag, " miso_oe A"}, misoOeA, 0);
    checkOutput({tag, " tready A"}, sReadyA, 1);
    checkOutput({tag, " tready B"}, sReadyB, 1);
    checkOutput({tag, " tvalid A"}, mValidA, 0);
    checkOutput({tag, " tdata B"}, mDataB, 0);
    checkOutput({tag, " overrun A"}, overrunA, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global timeout: got no finish, expected finish before 500 us");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    clearTx();
    waitClk(3);
    checkResetState("reset");
    arstn = 1'b1;
    waitClk(3);

    $display("[TB] mode 0/3 single word");
    mosiWord[0] = 8'h3C; txWord[0] = 8'hA5; txHas[0] = 1'b1;
    applyStimulus(1, -1);

    $display("[TB] back-to-back words");
    mosiWord[0] = 8'h01; mosiWord[1] = 8'h80; mosiWord[2] = 8'hFF;
    txWord[0] = 8'h11; txWord[1] = 8'h22; txWord[2] = 8'h33;
    txHas[0] = 1'b1; txHas[1] = 1'b1; txHas[2] = 1'b1;
    applyStimulus(3, -1);

    $display("[TB] tx underrun then late word");
    clearTx();
    mosiWord[0] = 8'hC3; mosiWord[1] = 8'h96; txWord[1] = 8'h5C; txHas[1] = 1'b1;
    applyStimulus(2, -1);

    $display("[TB] rx overrun");
    clearTx();
    mReady = 1'b0;
    mosiWord[0] = 8'h12; mosiWord[1] = 8'h34;
    applyStimulus(2, -1);
    checkOutput("held tdata A", mDataA, 8'h12);
    checkOutput("held tdata B", mDataB, 8'h12);
    checkOutput("held tvalid B", mValidB, 1);
    mReady = 1'b1;
    modelHeld = 1'b0;
    waitClk(3);
    checkOutput("drained tvalid A", mValidA, 0);

    $display("[TB] partial word then full word");
    mosiWord[0] = 8'hFF; txWord[0] = 8'hE7; txHas[0] = 1'b1;
    applyStimulus(1, 5);
    clearTx();
    mosiWord[0] = 8'h5A;
    applyStimulus(1, -1);

    $display("[TB] reset mid-word");
    csN = 1'b0;
    waitClk(4);
    for (int i = 0; i < 3; i++) begin
      mosi = 1'b1; sclkB = 1'b0; waitClk(HALF);
      sclkA = 1'b1; sclkB = 1'b1; waitClk(HALF);
      sclkA = 1'b0; waitClk(HALF);
    end
    pushTx(8'h77);
    checkOutput("tready A filled", sReadyA, 0);
    arstn = 1'b0; csN = 1'b1;
    waitClk(2);
    checkResetState("mid reset");
    arstn = 1'b1;
    expOverrun = 1'b0;
    modelHeld = 1'b0;
    waitClk(3);
    mosiWord[0] = 8'h9D; txWord[0] = 8'h4B; txHas[0] = 1'b1;
    applyStimulus(1, -1);

    $display("[TB] random frames");
    for (int f = 0; f < 12; f++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int k = 0; k < 8; k++) begin
        mosiWord[k] = W'($urandom);
        txWord[k]   = W'($urandom);
        txHas[k]    = 1'($urandom_range(0, 1));
      end
      applyStimulus(n, -1);
    end

    waitClk(4);
    checkOutput("scoreboard A empty", expA.size(), 0);
    checkOutput("scoreboard B empty", expB.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
